// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone-style arbiter with registered grant FSM,
// round-robin or fixed-priority arbitration, and a per-transaction watchdog.
module wb_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ROUND_ROBIN    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic           sel1;
    logic           g_stb;
    logic           timeout;
    logic           ack;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;

        sel1    = (state_q == GRANT1);
        g_stb   = sel1 ? m1_stb_i : m0_stb_i;
        timeout = (TIMEOUT_CYCLES > 0) && (timer_q == TMAX);
        ack     = s_ack_i && g_stb && !timeout;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (m0_stb_i && m1_stb_i) begin
                    // last_q==0 means master 0 was served last, so master 1 takes its turn
                    state_d = (ROUND_ROBIN && !last_q) ? GRANT1 : GRANT0;
                end else if (m0_stb_i) begin
                    state_d = GRANT0;
                end else if (m1_stb_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (timeout || ack) begin
                    state_d = IDLE;
                    last_d  = sel1;
                end else if (!g_stb) begin
                    state_d = IDLE;
                end else if (timer_q != TMAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset blanks every output immediately, ahead of the state register settling
        if (!rst_i && state_q != IDLE) begin
            s_stb_o  = g_stb && !timeout;
            s_we_o   = sel1 ? m1_we_i   : m0_we_i;
            s_adr_o  = sel1 ? m1_adr_i  : m0_adr_i;
            s_data_o = sel1 ? m1_data_i : m0_data_i;
            s_sel_o  = sel1 ? m1_sel_i  : m0_sel_i;
            grant_o  = sel1 ? 2'b10 : 2'b01;
            if (sel1) begin
                m1_data_o = s_data_i;
                m1_ack_o  = ack;
                m1_err_o  = timeout;
            end else begin
                m0_data_o = s_data_i;
                m0_ack_o  = ack;
                m0_err_o  = timeout;
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: two instances (round-robin with 4-cycle watchdog, fixed
// priority with watchdog off) driven in parallel and compared to a transaction model.
module tb_wb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_stb, m0_we, m1_stb, m1_we, s_ack;
    logic [31:0] m0_adr, m0_data, m1_adr, m1_data, s_data;
    logic [3:0]  m0_sel, m1_sel;

    logic [31:0] a_m0_data, a_m1_data, a_s_adr, a_s_data;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;
    logic [31:0] b_m0_data, b_m1_data, b_s_adr, b_s_data;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(4), .ROUND_ROBIN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_data_i(m0_data),
        .m0_sel_i(m0_sel), .m0_data_o(a_m0_data), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_data_i(m1_data),
        .m1_sel_i(m1_sel), .m1_data_o(a_m1_data), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_data_o(a_s_data),
        .s_sel_o(a_s_sel), .s_data_i(s_data), .s_ack_i(s_ack), .grant_o(a_grant)
    );

    wb_bus_arbiter #(.TIMEOUT_CYCLES(0), .ROUND_ROBIN(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_data_i(m0_data),
        .m0_sel_i(m0_sel), .m0_data_o(b_m0_data), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_data_i(m1_data),
        .m1_sel_i(m1_sel), .m1_data_o(b_m1_data), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_data_o(b_s_data),
        .s_sel_o(b_s_sel), .s_data_i(s_data), .s_ack_i(s_ack), .grant_o(b_grant)
    );

    typedef struct packed {
        logic        s_stb;
        logic        s_we;
        logic [31:0] s_adr;
        logic [31:0] s_data;
        logic [3:0]  s_sel;
        logic [31:0] d0;
        logic        a0;
        logic        e0;
        logic [31:0] d1;
        logic        a1;
        logic        e1;
        logic [1:0]  grant;
    } outs_t;

    int errors = 0;
    int checks = 0;

    // Transaction model: owner (0 none, 1 master0, 2 master1), who was last served,
    // and how many grant cycles the current transaction has gone unacked.
    int owner [2];
    int last  [2];
    int waited[2];

    function automatic int tmo_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic outs_t model_out(input int k);
        outs_t o;
        int    n;
        bit    stbn, to;
        o = '0;
        if (rst || owner[k] == 0) return o;
        n    = owner[k] - 1;
        stbn = (n == 1) ? m1_stb : m0_stb;
        to   = (tmo_of(k) > 0) && (waited[k] == tmo_of(k));
        o.s_stb  = stbn && !to;
        o.s_we   = (n == 1) ? m1_we   : m0_we;
        o.s_adr  = (n == 1) ? m1_adr  : m0_adr;
        o.s_data = (n == 1) ? m1_data : m0_data;
        o.s_sel  = (n == 1) ? m1_sel  : m0_sel;
        o.grant  = (n == 1) ? 2'b10 : 2'b01;
        if (n == 1) begin
            o.d1 = s_data; o.a1 = s_ack && o.s_stb; o.e1 = to;
        end else begin
            o.d0 = s_data; o.a0 = s_ack && o.s_stb; o.e0 = to;
        end
        return o;
    endfunction

    function automatic void model_step(input int k);
        int n;
        bit stbn, to;
        if (rst) begin
            owner[k] = 0; last[k] = 1; waited[k] = 0;
            return;
        end
        if (owner[k] == 0) begin
            waited[k] = 0;
            if (m0_stb && m1_stb) owner[k] = (k == 0) ? (1 - last[k]) + 1 : 1;
            else if (m0_stb)      owner[k] = 1;
            else if (m1_stb)      owner[k] = 2;
        end else begin
            n    = owner[k] - 1;
            stbn = (n == 1) ? m1_stb : m0_stb;
            to   = (tmo_of(k) > 0) && (waited[k] == tmo_of(k));
            if (to || (stbn && s_ack)) begin
                owner[k] = 0; last[k] = n;
            end else if (!stbn) begin
                owner[k] = 0;
            end else begin
                waited[k]++;
            end
        end
    endfunction

    function automatic outs_t obs_of(input int k);
        if (k == 0)
            return {a_s_stb, a_s_we, a_s_adr, a_s_data, a_s_sel, a_m0_data, a_m0_ack,
                    a_m0_err, a_m1_data, a_m1_ack, a_m1_err, a_grant};
        return {b_s_stb, b_s_we, b_s_adr, b_s_data, b_s_sel, b_m0_data, b_m0_ack,
                b_m0_err, b_m1_data, b_m1_ack, b_m1_err, b_grant};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k);
        outs_t e, o;
        string p;
        e = model_out(k);
        o = obs_of(k);
        p = (k == 0) ? "A." : "B.";
        chk({p, "s_stb"},  o.s_stb,  e.s_stb);
        chk({p, "s_we"},   o.s_we,   e.s_we);
        chk({p, "s_adr"},  o.s_adr,  e.s_adr);
        chk({p, "s_data"}, o.s_data, e.s_data);
        chk({p, "s_sel"},  o.s_sel,  e.s_sel);
        chk({p, "m0_data"}, o.d0, e.d0);
        chk({p, "m0_ack"},  o.a0, e.a0);
        chk({p, "m0_err"},  o.e0, e.e0);
        chk({p, "m1_data"}, o.d1, e.d1);
        chk({p, "m1_ack"},  o.a1, e.a1);
        chk({p, "m1_err"},  o.e1, e.e1);
        chk({p, "grant"},   o.grant, e.grant);
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic new_req(input int k, input int p);
        if (k == 0) begin
            m0_stb = ($urandom % 100) < p;
            m0_we = $urandom; m0_adr = $urandom; m0_data = $urandom; m0_sel = $urandom;
        end else begin
            m1_stb = ($urandom % 100) < p;
            m1_we = $urandom; m1_adr = $urandom; m1_data = $urandom; m1_sel = $urandom;
        end
    endtask

    task automatic upd_master(input int k, input bit done, input int p, input int pab);
        logic stb;
        stb = (k == 0) ? m0_stb : m1_stb;
        if (done || !stb) begin
            new_req(k, p);
        end else if (($urandom % 100) < pab) begin
            if (k == 0) m0_stb = 1'b0;
            else        m1_stb = 1'b0;
        end
    endtask

    task automatic traffic(input int n, input int wmin, input int wmax,
                           input int p0, input int p1, input int pab);
        int    wcnt = 0;
        int    wtgt = wmin;
        outs_t e;
        for (int i = 0; i < n; i++) begin
            s_ack = 1'b0;
            e = model_out(0);
            if (e.s_stb) begin
                s_ack = (wcnt >= wtgt);
                wcnt++;
            end else begin
                wcnt = 0;
                wtgt = $urandom_range(wmax, wmin);
            end
            s_data = $urandom;
            e = model_out(0);
            step();
            upd_master(0, e.a0 || e.e0, p0, pab);
            upd_master(1, e.a1 || e.e1, p1, pab);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            owner[k] = 0; last[k] = 1; waited[k] = 0;
        end
        rst = 1'b1;
        m0_stb = 0; m0_we = 0; m0_adr = 0; m0_data = 0; m0_sel = 0;
        m1_stb = 0; m1_we = 0; m1_adr = 0; m1_data = 0; m1_sel = 0;
        s_ack = 0; s_data = 0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single read from master 0 with a zero-wait slave
        m0_stb = 1; m0_we = 0; m0_adr = 32'h1000_0010; m0_sel = 4'hF;
        step();
        s_ack = 1; s_data = 32'hDEAD_BEEF;
        #1;
        chk("s1_m0_ack", a_m0_ack, 1);
        chk("s1_m0_data", a_m0_data, 32'hDEAD_BEEF);
        chk("s1_grant", a_grant, 2'b01);
        chk("s1_s_stb", a_s_stb, 1);
        chk("s1_m1_ack", a_m1_ack, 0);
        step();
        m0_stb = 0; s_ack = 0;
        #1;
        chk("s1_grant_idle", a_grant, 2'b00);
        chk("s1_stb_idle", a_s_stb, 0);
        step();

        // Contention right after reset: master 0 wins on both variants
        do_reset();
        m0_stb = 1; m0_adr = 32'h0000_A000; m1_stb = 1; m1_adr = 32'h0000_B000;
        step();
        #1;
        chk("s2_first_grant_rr", a_grant, 2'b01);
        chk("s2_first_grant_fp", b_grant, 2'b01);
        chk("s2_adr", a_s_adr, 32'h0000_A000);
        traffic(24, 2, 2, 100, 100, 0);
        // Master 0 goes quiet after its next ack; master 1 still waiting
        traffic(16, 2, 2, 0, 100, 0);

        // Watchdog abort of a master 1 write that the slave never acks
        do_reset();
        m0_stb = 0; m1_stb = 1; m1_we = 1; m1_adr = 32'h2000_0000; m1_data = 32'h1234_5678;
        s_ack = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s4_stb_high", a_s_stb, 1);
            chk("s4_no_err", a_m1_err, 0);
            step();
        end
        s_ack = 1;
        #1;
        chk("s4_err", a_m1_err, 1);
        chk("s4_stb_forced_low", a_s_stb, 0);
        chk("s4_ack_ignored", a_m1_ack, 0);
        chk("s4_grant", a_grant, 2'b10);
        step();
        m1_stb = 0; s_ack = 0;
        #1;
        chk("s4_idle", a_grant, 2'b00);
        step();

        // Reset asserted between edges in the middle of a master 0 grant
        m0_stb = 1; m0_adr = 32'h3000_0000;
        step();
        s_ack = 1;
        #1;
        chk("s5_pre_ack", a_m0_ack, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("s5_stb_zero", a_s_stb, 0);
        chk("s5_ack_zero", a_m0_ack, 0);
        chk("s5_grant_zero", a_grant, 2'b00);
        chk("s5_b_grant_zero", b_grant, 2'b00);
        step();
        rst = 1'b0; s_ack = 0; m0_stb = 1; m1_stb = 1;
        step();
        #1;
        chk("s5_post_reset_grant", a_grant, 2'b01);
        m0_stb = 0; m1_stb = 0;
        step();
        step();

        // Master 0 abandons its grant while master 1 waits
        do_reset();
        m0_stb = 1; m1_stb = 1;
        step();
        m0_stb = 0;
        #1;
        chk("s6_no_ack", a_m0_ack, 0);
        chk("s6_no_err", a_m0_err, 0);
        step();
        #1;
        chk("s6_idle", a_grant, 2'b00);
        step();
        #1;
        chk("s6_m1_granted", a_grant, 2'b10);
        s_ack = 1;
        step();
        m1_stb = 0; s_ack = 0;
        step();

        // Randomised traffic including aborts and watchdog expiries
        traffic(1500, 0, 6, 55, 55, 4);
        traffic(300, 0, 2, 100, 100, 0);
        do_reset();
        traffic(300, 0, 5, 40, 70, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
